// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response bundle of the RV32M multiply/divide unit.
// master = issuing side (decode/writeback), slave = the unit.
interface mul_div_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] busA;
  logic [31:0] busB;
  logic        out_valid;
  logic        out_ready;
  logic        RegWr;
  logic [4:0]  Rw;
  logic [31:0] busW;

  modport master (
    output in_valid, funct3, rd, busA, busB, out_ready,
    input  in_ready, out_valid, RegWr, Rw, busW
  );

  modport slave (
    input  in_valid, funct3, rd, busA, busB, out_ready,
    output in_ready, out_valid, RegWr, Rw, busW
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide, one radix-2 step per cycle.
// Ports: WrClk/rst (sync, active-high); in_valid/in_ready + funct3, rd,
// busA, busB request; out_valid/out_ready response driving RegWr, Rw, busW.
module mul_div_unit (
  input  logic        WrClk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        RegWr,
  output logic [4:0]  Rw,
  output logic [31:0] busW
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL = 3'd0;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIVU = 3'd5;
  localparam logic [2:0] OP_REMU = 3'd7;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] res_q, res_d;

  logic        a_sgn, b_sgn;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        is_div, div_zero, div_ovf;

  logic [32:0] mul_sum;
  logic [63:0] mul_nx;
  logic [32:0] div_sh;
  logic [32:0] div_sub;
  logic        div_ge;
  logic [63:0] div_nx;
  logic [63:0] step_nx;
  logic [63:0] prod_f;
  logic [31:0] quo_f, rem_f;
  logic [31:0] fix_res;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE) && !rst;
  assign RegWr     = out_valid && out_ready;
  assign Rw        = rd_q;
  assign busW      = res_q;

  // Operand signedness by op.
  always_comb begin
    a_sgn = 1'b1;
    b_sgn = 1'b1;
    unique case (funct3)
      OP_MULHSU: b_sgn = 1'b0;
      OP_MULHU, OP_DIVU, OP_REMU: begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
      end
      default: ;
    endcase
  end

  assign a_neg = a_sgn && busA[31];
  assign b_neg = b_sgn && busB[31];
  assign a_mag = a_neg ? (~busA + 32'd1) : busA;
  assign b_mag = b_neg ? (~busB + 32'd1) : busB;

  assign is_div   = funct3[2];
  assign div_zero = is_div && (busB == 32'd0);
  assign div_ovf  = is_div && !funct3[0]
                 && (busA == 32'h8000_0000)
                 && (busB == 32'hFFFF_FFFF);

  // acc holds {hi, multiplier} for multiply and {rem, quotient} for divide.
  assign mul_sum = {1'b0, acc_q[63:32]}
                 + {1'b0, (acc_q[0] ? b_q : 32'd0)};
  assign mul_nx  = {mul_sum, acc_q[31:1]};

  assign div_sh  = acc_q[63:31];
  assign div_ge  = div_sh >= {1'b0, b_q};
  assign div_sub = div_sh - {1'b0, b_q};
  assign div_nx  = {(div_ge ? div_sub[31:0] : div_sh[31:0]),
                    acc_q[30:0], div_ge};

  assign step_nx = op_q[2] ? div_nx : mul_nx;

  // Sign fix-up on the final step; sb_q is 0 for unsigned multiplicands.
  assign prod_f = (sa_q ^ sb_q) ? (~step_nx + 64'd1) : step_nx;
  assign quo_f  = (sa_q ^ sb_q) ? (~step_nx[31:0] + 32'd1)
                                : step_nx[31:0];
  assign rem_f  = sa_q ? (~step_nx[63:32] + 32'd1) : step_nx[63:32];

  always_comb begin
    fix_res = prod_f[31:0];
    unique case (1'b1)
      (op_q == OP_MUL):            fix_res = prod_f[31:0];
      (!op_q[2] && op_q != OP_MUL): fix_res = prod_f[63:32];
      (op_q[2] && !op_q[1]):       fix_res = quo_f;
      (op_q[2] && op_q[1]):        fix_res = rem_f;
      default:                     fix_res = prod_f[31:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d  = funct3;
          rd_d  = rd;
          b_d   = b_mag;
          acc_d = {32'd0, a_mag};
          sa_d  = a_neg;
          sb_d  = b_neg;
          cnt_d = 5'd31;
          if (div_zero) begin
            state_d = DONE;
            res_d   = funct3[1] ? busA : 32'hFFFF_FFFF;
          end else if (div_ovf) begin
            state_d = DONE;
            res_d   = funct3[1] ? 32'd0 : 32'h8000_0000;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = step_nx;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = DONE;
          cnt_d   = 5'd0;
          res_d   = fix_res;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge WrClk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit.
// Directed RV32M cases, special cases, backpressure, reset abort, random ops.
module tb_mul_div_unit;

  localparam int LAT_ITER = 32;
  localparam int LAT_FAST = 0;

  logic WrClk;
  logic rst;
  int   n_chk;
  int   n_fail;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  mul_div_unit_if mif();

  mul_div_unit dut (
    .WrClk     (WrClk),
    .rst       (rst),
    .in_valid  (mif.in_valid),
    .in_ready  (mif.in_ready),
    .funct3    (mif.funct3),
    .rd        (mif.rd),
    .busA      (mif.busA),
    .busB      (mif.busB),
    .out_valid (mif.out_valid),
    .out_ready (mif.out_ready),
    .RegWr     (mif.RegWr),
    .Rw        (mif.Rw),
    .busW      (mif.busW)
  );

  initial WrClk = 1'b0;
  always #5 WrClk = ~WrClk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_val(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa;
    logic [63:0] xb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    logic        ovf;
    xa  = {{32{a[31]}}, a};
    xb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = xa * xb; return p[31:0]; end
      3'd1: begin p = xa * xb; return p[63:32]; end
      3'd2: begin p = xa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (f[2] && b == 0) return LAT_FAST;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return LAT_FAST;
    return LAT_ITER;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!mif.in_ready && n < 50) begin
      @(negedge WrClk);
      n++;
    end
    if (!mif.in_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Drive one request, accept it, then scramble the operand buses.
  task automatic start_op(input logic [2:0] f, input logic [4:0] r,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] val, input int lat);
    exp_t e;
    @(negedge WrClk);
    wait_ready();
    mif.in_valid = 1'b1;
    mif.funct3   = f;
    mif.rd       = r;
    mif.busA     = a;
    mif.busB     = b;
    @(posedge WrClk);
    e.rd  = r;
    e.val = val;
    e.lat = lat;
    sb_q.push_back(e);
    #1;
    mif.in_valid = 1'b0;
    mif.funct3   = 3'($urandom);
    mif.rd       = 5'($urandom);
    mif.busA     = $urandom;
    mif.busB     = $urandom;
  endtask

  task automatic wait_out(output exp_t e);
    int edges;
    edges = 0;
    while (!mif.out_valid && edges < 40) begin
      @(posedge WrClk);
      #1;
      edges++;
    end
    e = sb_q.pop_front();
    check("latency", 32'(edges), 32'(e.lat));
    check("out_valid", 32'(mif.out_valid), 32'd1);
    check("Rw", 32'(mif.Rw), 32'(e.rd));
    check("busW", mif.busW, e.val);
  endtask

  task automatic drain();
    mif.out_ready = 1'b1;
    #1;
    check("RegWr", 32'(mif.RegWr), 32'd1);
    @(posedge WrClk);
    #1;
    check("ov_low", 32'(mif.out_valid), 32'd0);
    mif.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] val, input int lat);
    exp_t e;
    start_op(f, r, a, b, val, lat);
    wait_out(e);
    drain();
  endtask

  initial begin
    exp_t e;
    int   pulses;
    int   seen;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    n_chk  = 0;
    n_fail = 0;
    rst           = 1'b1;
    mif.in_valid  = 1'b0;
    mif.out_ready = 1'b0;
    mif.funct3    = 3'd0;
    mif.rd        = 5'd0;
    mif.busA      = 32'd0;
    mif.busB      = 32'd0;

    repeat (2) @(posedge WrClk);
    #1;
    check("rst_in_ready", 32'(mif.in_ready), 32'd0);
    check("rst_out_valid", 32'(mif.out_valid), 32'd0);
    check("rst_busW", mif.busW, 32'd0);
    check("rst_Rw", 32'(mif.Rw), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(mif.in_ready), 32'd1);

    run_op(3'd0, 5'd5, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, LAT_ITER);
    run_op(3'd3, 5'd1, '1, '1, 32'hFFFF_FFFE, LAT_ITER);
    run_op(3'd1, 5'd2, '1, '1, 32'h0000_0000, LAT_ITER);
    run_op(3'd2, 5'd3, '1, '1, 32'hFFFF_FFFF, LAT_ITER);
    run_op(3'd4, 5'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_ITER);
    run_op(3'd6, 5'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_ITER);
    run_op(3'd5, 5'd7, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, LAT_ITER);
    run_op(3'd5, 5'd8, 32'd123, 32'd0, 32'hFFFF_FFFF, LAT_FAST);
    run_op(3'd7, 5'd9, 32'd123, 32'd0, 32'd123, LAT_FAST);
    run_op(3'd4, 5'd10, 32'h8000_0000, '1, 32'h8000_0000, LAT_FAST);
    run_op(3'd6, 5'd11, 32'h8000_0000, '1, 32'd0, LAT_FAST);
    run_op(3'd4, 5'd12, 32'd55, 32'd0, 32'hFFFF_FFFF, LAT_FAST);
    run_op(3'd6, 5'd13, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_FAST);
    run_op(3'd0, 5'd0, 32'd1000, 32'd1000, 32'd1000000, LAT_ITER);
    run_op(3'd6, 5'd14, 32'd7, 32'hFFFF_FFFE, 32'd1, LAT_ITER);

    // Backpressure with a pending request held on in_valid.
    start_op(3'd0, 5'd5, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, LAT_ITER);
    wait_out(e);
    mif.in_valid = 1'b1;
    mif.funct3   = 3'd5;
    mif.rd       = 5'd20;
    mif.busA     = 32'd100;
    mif.busB     = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge WrClk);
      #1;
      check("bp_valid", 32'(mif.out_valid), 32'd1);
      check("bp_Rw", 32'(mif.Rw), 32'(e.rd));
      check("bp_busW", mif.busW, e.val);
      check("bp_RegWr", 32'(mif.RegWr), 32'd0);
      check("bp_in_ready", 32'(mif.in_ready), 32'd0);
    end
    mif.out_ready = 1'b1;
    #1;
    pulses = 32'(mif.RegWr);
    @(posedge WrClk);
    #1;
    check("hs_no_accept", 32'(mif.in_ready), 32'd1);
    check("hs_ov_low", 32'(mif.out_valid), 32'd0);
    mif.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulses += 32'(mif.RegWr);
      @(posedge WrClk);
      #1;
    end
    check("bp_pulses", 32'(pulses), 32'd1);
    mif.out_ready = 1'b0;

    // Reset pulse while the counter sits at 15.
    start_op(3'd5, 5'd17, 32'd1000, 32'd9, 32'd111, LAT_ITER);
    repeat (16) @(posedge WrClk);
    #1;
    mif.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(mif.in_ready), 32'd0);
    check("mid_rst_RegWr", 32'(mif.RegWr), 32'd0);
    @(posedge WrClk);
    #1;
    rst = 1'b0;
    mif.out_ready = 1'b0;
    #1;
    check("abort_busW", mif.busW, 32'd0);
    check("abort_Rw", 32'(mif.Rw), 32'd0);
    check("abort_ready", 32'(mif.in_ready), 32'd1);
    void'(sb_q.pop_front());
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge WrClk);
      #1;
      seen += 32'(mif.out_valid);
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    run_op(3'd5, 5'd17, 32'd1000, 32'd9, 32'd111, LAT_ITER);

    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i == 3) begin
        rf = 3'd6;
        ra = 32'h8000_0000;
        rb = '1;
      end
      if (i % 4 == 1) rb = 32'($urandom_range(1, 300));
      run_op(rf, 5'($urandom), ra, rb, ref_val(rf, ra, rb),
             ref_lat(rf, ra, rb));
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have the following ports:
- WrClk  in  1  core clock, the same net as the register-file write clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- funct3  in  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rd  in  5  destination register index.
- busA  in  32  rs1 operand from register-file read port 1.
- busB  in  32  rs2 operand from register-file read port 2.
- out_valid  out  1  result available.
- out_ready  in  1  writeback can consume the result.
- RegWr  out  1  register-file write enable.
- Rw  out  5  register-file write index.
- busW  out  32  register-file write data.

REQ-002 Clocking SHALL use one clock only; reset SHALL be synchronous and active-high.

Function
REQ-003 The state machine SHALL use the states IDLE, BUSY and DONE.
REQ-004 in_ready SHALL be high only in IDLE and while rst is low.
REQ-005 Acceptance SHALL occur on a rising edge where in_valid && in_ready; at that edge funct3, rd, busA and busB SHALL be captured.
REQ-006 After an accept, later changes on funct3, rd, busA or busB SHALL have no effect until the next accept.
REQ-007 On a normal accept the unit SHALL go IDLE->BUSY, load a 5-bit iteration counter with 31, and convert operands to magnitudes per signedness:
- MUL, MULH, DIV, REM: both operands signed.
- MULHSU: busA signed, busB unsigned.
- MULHU, DIVU, REMU: both operands unsigned.
REQ-008 BUSY SHALL perform one radix-2 step per cycle:
- Multiply: shift-add into a 64-bit product.
- Divide: restoring step producing a 32-bit quotient and a 32-bit remainder.
REQ-009 The counter SHALL decrement each BUSY cycle; the BUSY->DONE transition SHALL occur on the edge where the counter equals 0, so out_valid rises exactly 32 edges after the accepting edge.
REQ-010 On the BUSY->DONE edge a sign fix-up SHALL be applied:
- Product: negated if the operand signs differ (signed operands only).
- Quotient: negated if the dividend and divisor signs differ.
- Remainder: takes the sign of the dividend.
REQ-011 busW SHALL select:
- MUL: product[31:0].
- MULH, MULHSU, MULHU: product[63:32].
- DIV, DIVU: quotient.
- REM, REMU: remainder.
REQ-012 Division by zero SHALL skip BUSY and go IDLE->DONE on the accepting edge (latency 1 edge):
- Quotient = 0xFFFFFFFF for both DIV and DIVU.
- Remainder = busA.
REQ-013 Signed overflow (DIV/REM with busA=0x80000000, busB=0xFFFFFFFF) SHALL take the 1-edge path with quotient 0x80000000 and remainder 0.
REQ-014 In DONE, out_valid SHALL be 1, and Rw and busW SHALL be held stable until handshake.
REQ-015 RegWr SHALL equal out_valid && out_ready (combinational).
REQ-016 On the edge where out_valid && out_ready, the unit SHALL return to IDLE with out_valid low.
REQ-017 A new request SHALL NOT be accepted on the same edge as the output handshake.
REQ-018 When rd = 0, the unit SHALL compute and handshake normally with Rw = 0; the write is discarded downstream.
REQ-019 All arithmetic SHALL be modulo 2^32 / 2^64 with no exceptions or flags.

Reset
REQ-020 While rst is high at a rising edge, the unit SHALL enter IDLE, clear the counter, and set out_valid = 0, Rw = 0, busW = 0; RegWr = 0 and in_ready = 0 while rst is asserted.
REQ-021 Reset asserted in BUSY or DONE SHALL abort the operation with no write issued; in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-022 MUL: funct3=0, busA=7, busB=0xFFFFFFFA (-6), rd=5 -> out_valid 32 edges after accept, Rw=5, busW=0xFFFFFFD6 (-42).
REQ-023 MULHU and MULH: busA=busB=0xFFFFFFFF -> MULHU busW=0xFFFFFFFE; MULH busW=0x00000000; MULHSU busW=0xFFFFFFFF.
REQ-024 DIV/REM: busA=0xFFFFFFF9 (-7), busB=2 -> DIV busW=0xFFFFFFFD (-3), REM busW=0xFFFFFFFF (-1); DIVU of the same operands busW=0x7FFFFFFC.
REQ-025 Special cases, each checked for 1-edge latency:
- DIVU busA=123, busB=0 -> busW=0xFFFFFFFF.
- REMU busA=123, busB=0 -> busW=123.
- DIV 0x80000000 / 0xFFFFFFFF -> busW=0x80000000.
REQ-026 Backpressure: out_ready held low for 10 cycles after out_valid -> out_valid, Rw and busW stable and RegWr=0 throughout; in_valid high the whole time with no accept; after out_ready=1, exactly one RegWr pulse, then in_ready=1 on the next cycle.
REQ-027 Reset mid-operation: rst pulsed 1 cycle at counter=15 -> out_valid never rises for that op, busW=0, next request completes correctly.
